ppu_vblank_sched: RTL

// Queues PPU register writes ($2000-$2007) from game/test logic and replays them on the CPU-side PPU bus only inside vblank.
// A replay window opens on each NMI rising edge; it optionally opens with a $2002 status read to clear the w latch,

---
 rtl/ppu_vblank_sched_if.sv | 23 ++
 rtl/ppu_vblank_sched.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/ppu_vblank_sched_if.sv
// Request and PPU-bus bundle for the vblank write scheduler.
// The master side is the requester together with the PPU register port.
// The slave side is the scheduler itself.
interface ppu_vblank_sched_if;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_reg;
   logic [7:0]  req_data;
   logic        rw;
   logic [15:0] addr;
   logic [7:0]  data_o;
   logic [7:0]  data_i;

   modport master (
      output req_valid, req_reg, req_data, data_i,
      input  req_ready, rw, addr, data_o
   );

   modport slave (
      input  req_valid, req_reg, req_data, data_i,
      output req_ready, rw, addr, data_o
   );
endinterface

// File: rtl/ppu_vblank_sched.sv
// ppu_vblank_sched
// Queues PPU register writes ($2000-$2007) and replays them on the CPU-side
// PPU bus only inside vblank. Each NMI rising edge opens a window. A window
// optionally starts with a $2002 status read, which clears the PPU w latch.
// It then issues one queued write per clock, up to MAX_WRITES per window.
module ppu_vblank_sched #(
   parameter int DEPTH           = 16,
   parameter int MAX_WRITES      = 32,
   parameter int PRE_STATUS_READ = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     nmi,
   ppu_vblank_sched_if.slave        bus,
   output logic [7:0]               status_o,
   output logic [$clog2(DEPTH):0]   pending,
   output logic                     busy,
   output logic                     window_done
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STATUS = 2'd1,
      S_DRAIN  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t          r_state;
   logic            r_nmi;
   logic [10:0]     r_mem [DEPTH];
   logic [AW-1:0]   r_wptr;
   logic [AW-1:0]   r_rptr;
   logic [CW-1:0]   r_count;
   logic [7:0]      r_budget;
   logic [7:0]      r_status;
   logic            r_busy;
   logic            r_window_done;

   logic            w_nmi_re;
   logic            w_ready;
   logic            w_push;
   logic            w_pop;
   logic [10:0]     w_head;
   logic            w_last_entry;
   logic            w_last_budget;
   logic            w_rw;
   logic [15:0]     w_addr;
   logic [7:0]      w_data;

   // Rising NMI marks vblank start; NMI already high at reset release is ignored.
   assign w_nmi_re = nmi & ~r_nmi;

   // Never accept while reset is asserted, otherwise whenever there is room.
   assign w_ready = ~rst & (r_count < CW'(DEPTH));
   assign w_push  = bus.req_valid & w_ready;

   // Every DRAIN cycle consumes the head entry.
   assign w_pop   = (r_state == S_DRAIN);
   assign w_head  = r_mem[r_rptr];

   // This pop empties the queue only if nothing arrives in the same cycle.
   assign w_last_entry  = (r_count == CW'(1)) & ~w_push;
   assign w_last_budget = (r_budget == 8'd1);

   // Track the previous NMI level for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_nmi <= 1'b1;
      end else begin
         r_nmi <= nmi;
      end
   end

   // Queue storage: {register index, data}; contents are don't-care when empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= {bus.req_reg, bus.req_data};
      end
   end

   // Queue pointers and occupancy; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + AW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Window sequencer with registered busy / window_done / status capture.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state       <= S_IDLE;
         r_budget      <= 8'd0;
         r_status      <= 8'd0;
         r_busy        <= 1'b0;
         r_window_done <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_window_done <= 1'b0;
               if (w_nmi_re && (r_count != CW'(0))) begin
                  r_budget <= 8'(MAX_WRITES);
                  r_busy   <= 1'b1;
                  if (PRE_STATUS_READ != 0) begin
                     r_state <= S_STATUS;
                  end else begin
                     r_state <= S_DRAIN;
                  end
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_STATUS: begin
               r_status <= bus.data_i;
               r_busy   <= 1'b1;
               r_state  <= S_DRAIN;
            end
            S_DRAIN: begin
               r_budget <= r_budget - 8'd1;
               if (w_last_entry || w_last_budget) begin
                  r_busy        <= 1'b0;
                  r_window_done <= 1'b1;
                  r_state       <= S_DONE;
               end else begin
                  r_busy  <= 1'b1;
                  r_state <= S_DRAIN;
               end
            end
            S_DONE: begin
               r_busy        <= 1'b0;
               r_window_done <= 1'b0;
               r_state       <= S_IDLE;
            end
            default: begin
               r_busy        <= 1'b0;
               r_window_done <= 1'b0;
               r_state       <= S_IDLE;
            end
         endcase
      end
   end

   // Bus decode from state and queue head; idle is a read of address 0.
   always_comb begin
      w_rw   = 1'b1;
      w_addr = 16'h0000;
      w_data = 8'h00;
      case (r_state)
         S_STATUS: begin
            w_addr = 16'h2002;
         end
         S_DRAIN: begin
            w_rw   = 1'b0;
            w_addr = 16'h2000 | {13'd0, w_head[10:8]};
            w_data = w_head[7:0];
         end
         default: begin
            w_rw   = 1'b1;
            w_addr = 16'h0000;
            w_data = 8'h00;
         end
      endcase
   end

   assign bus.req_ready = w_ready;
   assign bus.rw        = w_rw;
   assign bus.addr      = w_addr;
   assign bus.data_o    = w_data;
   assign status_o      = r_status;
   assign pending       = r_count;
   assign busy          = r_busy;
   assign window_done   = r_window_done;

endmodule
